disp_sched: RTL and testbench



---
 rtl/disp_sched.sv | 186 ++++++++++++++++++
 tb/tb_disp_sched.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/disp_sched.sv
// disp_sched: digit scan, storage of the two 16-bit display halves, and round-robin write arbitration with frame-based ownership locks.
// Optional blink gating of the half enables is compiled in when DISP_SCHED_BLINK_EN is defined.
module disp_sched #(
  parameter int unsigned PRESCALE     = 1000,
  parameter int unsigned HOLD_FRAMES  = 4,
  parameter int unsigned BLINK_FRAMES = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_a,
  input  logic        req_b,
  input  logic        tgt_a,
  input  logic        tgt_b,
  input  logic [15:0] val_a,
  input  logic [15:0] val_b,
  output logic        ack_a,
  output logic        ack_b,
  input  logic        clear,
  input  logic        blink1,
  input  logic        blink2,
  output logic [15:0] outval1,
  output logic [15:0] outval2,
  output logic        display_out1,
  output logic        display_out2,
  output logic [2:0]  sel,
  output logic        frame
);
  localparam int unsigned CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned LW = (HOLD_FRAMES > 0) ? $clog2(HOLD_FRAMES + 1) : 1;

  typedef enum logic [1:0] {OWN_NONE, OWN_A, OWN_B} owner_e;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    sel_q, sel_d;
  logic          frame_q, frame_d;
  logic          rr_q, rr_d;  // 0: A wins the next contested tie
  logic [15:0]   val_q [2];
  logic [15:0]   val_d [2];
  logic [1:0]    written_q, written_d;
  owner_e        owner_q [2];
  owner_e        owner_d [2];
  logic [LW-1:0] lock_q [2];
  logic [LW-1:0] lock_d [2];
  logic [1:0]    elig_a, elig_b;
  logic          wa, wb;

  always_comb begin
    cnt_d   = cnt_q + CW'(1);
    sel_d   = sel_q;
    frame_d = 1'b0;
    if (cnt_q == CW'(PRESCALE - 1)) begin
      cnt_d   = '0;
      sel_d   = sel_q + 3'd1;
      frame_d = (sel_q == 3'd7);
    end
  end

  always_comb begin
    for (int unsigned h = 0; h < 2; h++) begin
      elig_a[h] = (owner_q[h] != OWN_B) || (lock_q[h] == '0);
      elig_b[h] = (owner_q[h] != OWN_A) || (lock_q[h] == '0);
    end
    wa    = req_a && elig_a[tgt_a];
    wb    = req_b && elig_b[tgt_b];
    ack_a = 1'b0;
    ack_b = 1'b0;
    rr_d  = rr_q;
    if (reset && !clear) begin
      if (wa && wb && (tgt_a == tgt_b)) begin
        ack_a = !rr_q;
        ack_b = rr_q;
        rr_d  = !rr_q;
      end else begin
        ack_a = wa;
        ack_b = wb;
      end
    end
  end

  // Precedence per half: frame decrement, then accepted write, then clear.
  always_comb begin
    for (int unsigned h = 0; h < 2; h++) begin
      val_d[h]     = val_q[h];
      written_d[h] = written_q[h];
      owner_d[h]   = owner_q[h];
      lock_d[h]    = lock_q[h];
      if (frame_q && (lock_q[h] != '0)) begin
        lock_d[h] = lock_q[h] - LW'(1);
        if (lock_q[h] == LW'(1)) owner_d[h] = OWN_NONE;
      end
      if (ack_a && (tgt_a == h[0])) begin
        val_d[h]     = val_a;
        written_d[h] = 1'b1;
        owner_d[h]   = OWN_A;
        lock_d[h]    = LW'(HOLD_FRAMES);
      end
      if (ack_b && (tgt_b == h[0])) begin
        val_d[h]     = val_b;
        written_d[h] = 1'b1;
        owner_d[h]   = OWN_B;
        lock_d[h]    = LW'(HOLD_FRAMES);
      end
      if (clear) begin
        val_d[h]     = '0;
        written_d[h] = 1'b0;
        owner_d[h]   = OWN_NONE;
        lock_d[h]    = '0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt_q     <= '0;
      sel_q     <= '0;
      frame_q   <= 1'b0;
      rr_q      <= 1'b0;
      written_q <= '0;
      for (int unsigned h = 0; h < 2; h++) begin
        val_q[h]   <= '0;
        owner_q[h] <= OWN_NONE;
        lock_q[h]  <= '0;
      end
    end else begin
      cnt_q     <= cnt_d;
      sel_q     <= sel_d;
      frame_q   <= frame_d;
      rr_q      <= rr_d;
      written_q <= written_d;
      for (int unsigned h = 0; h < 2; h++) begin
        val_q[h]   <= val_d[h];
        owner_q[h] <= owner_d[h];
        lock_q[h]  <= lock_d[h];
      end
    end
  end

`ifdef DISP_SCHED_BLINK_EN
  localparam int unsigned BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [BW-1:0] bcnt_q, bcnt_d;
  logic          phase_q, phase_d;
  logic [1:0]    disp_q, disp_d;

  always_comb begin
    bcnt_d  = bcnt_q;
    phase_d = phase_q;
    if (frame_q) begin
      if (bcnt_q == BW'(BLINK_FRAMES - 1)) begin
        bcnt_d  = '0;
        phase_d = !phase_q;
      end else begin
        bcnt_d = bcnt_q + BW'(1);
      end
    end
    disp_d = written_d & ~({blink2, blink1} & {2{~phase_d}});
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      bcnt_q  <= '0;
      phase_q <= 1'b0;
      disp_q  <= '0;
    end else begin
      bcnt_q  <= bcnt_d;
      phase_q <= phase_d;
      disp_q  <= disp_d;
    end
  end

  assign display_out1 = disp_q[0];
  assign display_out2 = disp_q[1];
`else
  logic unused_blink;
  assign unused_blink = blink1 ^ blink2 ^ (BLINK_FRAMES == 0);

  assign display_out1 = written_q[0];
  assign display_out2 = written_q[1];
`endif

  assign outval1 = val_q[0];
  assign outval2 = val_q[1];
  assign sel     = sel_q;
  assign frame   = frame_q;

endmodule

// File: tb/tb_disp_sched.sv
// Directed bench for disp_sched: a vector table for arbitration/clear, plus scan, lock-expiry, zero-hold and blink sequences.
module tb_disp_sched;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        req_a = 1'b0, req_b = 1'b0, tgt_a = 1'b0, tgt_b = 1'b0;
  logic [15:0] val_a = '0, val_b = '0;
  logic        clear = 1'b0, blink1 = 1'b0, blink2 = 1'b0;
  logic        ack_a, ack_b, display_out1, display_out2, frame;
  logic [15:0] outval1, outval2;
  logic [2:0]  sel;
  logic        ack_a0, ack_b0;
  logic [15:0] outval1_0;
  logic [15:0] unused0_outval2;
  logic        unused0_d1, unused0_d2, unused0_frame;
  logic [2:0]  unused0_sel;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  disp_sched #(.PRESCALE(4), .HOLD_FRAMES(4), .BLINK_FRAMES(2)) u_dut (
    .clock(clock), .reset(reset), .req_a(req_a), .req_b(req_b), .tgt_a(tgt_a), .tgt_b(tgt_b),
    .val_a(val_a), .val_b(val_b), .ack_a(ack_a), .ack_b(ack_b), .clear(clear),
    .blink1(blink1), .blink2(blink2), .outval1(outval1), .outval2(outval2),
    .display_out1(display_out1), .display_out2(display_out2), .sel(sel), .frame(frame));

  disp_sched #(.PRESCALE(4), .HOLD_FRAMES(0), .BLINK_FRAMES(2)) u_dut0 (
    .clock(clock), .reset(reset), .req_a(req_a), .req_b(req_b), .tgt_a(tgt_a), .tgt_b(tgt_b),
    .val_a(val_a), .val_b(val_b), .ack_a(ack_a0), .ack_b(ack_b0), .clear(clear),
    .blink1(blink1), .blink2(blink2), .outval1(outval1_0), .outval2(unused0_outval2),
    .display_out1(unused0_d1), .display_out2(unused0_d2), .sel(unused0_sel), .frame(unused0_frame));

  typedef struct {
    logic ra; logic ta; logic [15:0] va;
    logic rb; logic tgb; logic [15:0] vb;
    logic clr;
    logic ea; logic eb; logic [15:0] e1; logic [15:0] e2; logic ed1; logic ed2;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0; clear = 1'b0; blink1 = 1'b0; blink2 = 1'b0;
    req_b = 1'b0; req_a = 1'b1; tgt_a = 1'b0; val_a = 16'hDEAD;
    #1 check("ack_a while reset low", ack_a, 0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1; req_a = 1'b0;
  endtask

  initial begin
    int got;
    logic exp_a0 [3];
    logic exp_b0 [3];

    //         ra tA va        rb tB vb        clr  ea eb e1        e2        d1 d2
    vecs[0]  = '{0, 0, 16'h0000, 0, 0, 16'h0000, 0,   0, 0, 16'h0000, 16'h0000, 0, 0};
    vecs[1]  = '{1, 0, 16'h1234, 0, 0, 16'h0000, 0,   1, 0, 16'h1234, 16'h0000, 1, 0};
    vecs[2]  = '{0, 0, 16'h0000, 0, 0, 16'h0000, 0,   0, 0, 16'h1234, 16'h0000, 1, 0};
    vecs[3]  = '{1, 0, 16'hAAAA, 1, 1, 16'h5555, 0,   1, 1, 16'hAAAA, 16'h5555, 1, 1};
    vecs[4]  = '{0, 0, 16'h0000, 1, 0, 16'h7777, 0,   0, 0, 16'hAAAA, 16'h5555, 1, 1};
    vecs[5]  = '{1, 1, 16'h9999, 0, 0, 16'h0000, 0,   0, 0, 16'hAAAA, 16'h5555, 1, 1};
    vecs[6]  = '{1, 0, 16'h1111, 1, 1, 16'h2222, 0,   1, 1, 16'h1111, 16'h2222, 1, 1};
    vecs[7]  = '{1, 0, 16'h3333, 0, 0, 16'h0000, 1,   0, 0, 16'h0000, 16'h0000, 0, 0};
    vecs[8]  = '{1, 0, 16'h3333, 0, 0, 16'h0000, 0,   1, 0, 16'h3333, 16'h0000, 1, 0};
    vecs[9]  = '{0, 0, 16'h0000, 1, 0, 16'h4444, 0,   0, 0, 16'h3333, 16'h0000, 1, 0};
    vecs[10] = '{0, 0, 16'h0000, 0, 0, 16'h0000, 1,   0, 0, 16'h0000, 16'h0000, 0, 0};
    vecs[11] = '{1, 0, 16'h0A0A, 1, 0, 16'h0B0B, 0,   1, 0, 16'h0A0A, 16'h0000, 1, 0};
    vecs[12] = '{0, 0, 16'h0000, 0, 0, 16'h0000, 1,   0, 0, 16'h0000, 16'h0000, 0, 0};
    vecs[13] = '{1, 1, 16'h0A0A, 1, 1, 16'h0B0B, 0,   0, 1, 16'h0000, 16'h0B0B, 0, 1};

    // Arbitration, lock blocking and clear table.
    do_reset();
    for (int i = 0; i < 14; i++) begin
      req_a = vecs[i].ra; tgt_a = vecs[i].ta; val_a = vecs[i].va;
      req_b = vecs[i].rb; tgt_b = vecs[i].tgb; val_b = vecs[i].vb;
      clear = vecs[i].clr;
      #1;
      check($sformatf("v%0d ack_a", i), ack_a, vecs[i].ea);
      check($sformatf("v%0d ack_b", i), ack_b, vecs[i].eb);
      @(posedge clock);
      #1;
      check($sformatf("v%0d outval1", i), outval1, vecs[i].e1);
      check($sformatf("v%0d outval2", i), outval2, vecs[i].e2);
      check($sformatf("v%0d display_out1", i), display_out1, vecs[i].ed1);
      check($sformatf("v%0d display_out2", i), display_out2, vecs[i].ed2);
      @(negedge clock);
    end
    req_a = 1'b0; req_b = 1'b0; clear = 1'b0;

    // Scan: sel steps every 4 cycles, frame once per 32 cycles at sel wrap.
    do_reset();
    for (int k = 1; k <= 64; k++) begin
      @(posedge clock);
      #1;
      check($sformatf("scan sel k=%0d", k), sel, (k / 4) % 8);
      check($sformatf("scan frame k=%0d", k), frame, (k % 32) == 0);
      if (k == 1) begin
        check("post-reset outval1", outval1, 0);
        check("post-reset outval2", outval2, 0);
        check("post-reset enables", {display_out1, display_out2}, 0);
      end
    end

    // Lock expiry with HOLD_FRAMES=4: B gets in the cycle after the 4th frame pulse.
    do_reset();
    req_a = 1'b1; tgt_a = 1'b0; val_a = 16'h00A1;
    req_b = 1'b1; tgt_b = 1'b0; val_b = 16'h00B1;
    #1;
    check("lock first ack_a", ack_a, 1);
    check("lock first ack_b", ack_b, 0);
    @(posedge clock);
    #1;
    check("lock outval1 A", outval1, 16'h00A1);
    req_a = 1'b0;
    got = -1;
    for (int k = 1; k <= 200; k++) begin
      #1;
      if (ack_b) begin
        got = k;
        break;
      end
      @(posedge clock);
      #1;
    end
    check("lock B ack cycle", got, 129);
    @(posedge clock);
    #1;
    check("lock outval1 B", outval1, 16'h00B1);
    req_b = 1'b0;

    // HOLD_FRAMES=0: contested ties alternate A, B, A.
    do_reset();
    req_a = 1'b1; tgt_a = 1'b0; val_a = 16'h00A2;
    req_b = 1'b1; tgt_b = 1'b0; val_b = 16'h00B2;
    exp_a0 = '{1'b1, 1'b0, 1'b1};
    exp_b0 = '{1'b0, 1'b1, 1'b0};
    for (int c = 0; c < 3; c++) begin
      #1;
      check($sformatf("hold0 ack_a c%0d", c), ack_a0, exp_a0[c]);
      check($sformatf("hold0 ack_b c%0d", c), ack_b0, exp_b0[c]);
      @(posedge clock);
      #1;
      check($sformatf("hold0 outval1 c%0d", c), outval1_0, exp_a0[c] ? 16'h00A2 : 16'h00B2);
      @(negedge clock);
    end
    req_a = 1'b0; req_b = 1'b0;

    // Blink on half 2 only.
    do_reset();
    req_a = 1'b1; tgt_a = 1'b0; val_a = 16'h00C1;
    req_b = 1'b1; tgt_b = 1'b1; val_b = 16'h00C2;
    blink2 = 1'b1;
    @(posedge clock);
    #1;
    req_a = 1'b0; req_b = 1'b0;
    for (int k = 1; k <= 200; k++) begin
`ifdef DISP_SCHED_BLINK_EN
      if (k == 10 || k == 70 || k == 130 || k == 200) begin
        check($sformatf("blink display_out2 k=%0d", k), display_out2, (k == 70 || k == 200));
        check($sformatf("blink display_out1 k=%0d", k), display_out1, 1);
      end
`else
      if (k == 10 || k == 70) begin
        check($sformatf("noblink display_out2 k=%0d", k), display_out2, 1);
        check($sformatf("noblink display_out1 k=%0d", k), display_out1, 1);
      end
`endif
      @(posedge clock);
      #1;
    end
    blink2 = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
